// File: rtl/shift_arbiter2_pkg.sv
// Shared constants and types for the two-port shift arbiter and its barrel shifter.
package shift_arbiter2_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned AMT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
        logic              id;
    } shift_op_t;

endpackage

// File: rtl/barrel_shifter_right16.sv
// 16-bit logical right barrel shifter, zero fill; one mux stage per amount bit.
module barrel_shifter_right16
    import shift_arbiter2_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    input  logic              j0,
    input  logic              j1,
    input  logic              j2,
    input  logic              j3,
    output logic [DATA_W-1:0] y_c
);

    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
    logic [DATA_W-1:0] s3;

    assign s1  = j0 ? {1'b0, d[DATA_W-1:1]}  : d;
    assign s2  = j1 ? {2'b0, s1[DATA_W-1:2]} : s1;
    assign s3  = j2 ? {4'b0, s2[DATA_W-1:4]} : s2;
    assign y_c = j3 ? {8'b0, s3[DATA_W-1:8]} : s3;

endmodule

// File: rtl/shift_arbiter2.sv
// Round-robin arbiter and sequencer sharing one right barrel shifter between two requesters.
module shift_arbiter2
    import shift_arbiter2_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic              prio;
    shift_op_t         op;
    logic [DATA_W-1:0] shift_y;
    logic              grant0;
    logic              grant1;
    logic              accept0;
    logic              accept1;

    barrel_shifter_right16 u_shifter (
        .d   (op.data),
        .j0  (op.amt[0]),
        .j1  (op.amt[1]),
        .j2  (op.amt[2]),
        .j3  (op.amt[3]),
        .y_c (shift_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Lone requester always wins; under contention prio picks the winner.
    always_comb begin
        state_nxt  = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept0    = 1'b0;
        accept1    = 1'b0;
        unique case (state)
            IDLE: begin
                grant0     = req0_valid && (!req1_valid || !prio);
                grant1     = req1_valid && (!req0_valid || prio);
                req0_ready = grant0 && !reset;
                req1_ready = grant1 && !reset;
                accept0    = req0_ready && req0_valid;
                accept1    = req1_ready && req1_valid;
                if (accept0 || accept1) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: state_nxt = HOLD;
            HOLD: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio      <= 1'b0;
            op        <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
        end else begin
            // The loser of this accept gets the next contended turn.
            if (accept0) begin
                op   <= '{data: req0_data, amt: req0_amt, id: 1'b0};
                prio <= 1'b1;
            end else if (accept1) begin
                op   <= '{data: req1_data, amt: req1_amt, id: 1'b1};
                prio <= 1'b0;
            end
            if (state == SHIFT) begin
                rsp_data  <= shift_y;
                rsp_id    <= op.id;
                rsp_valid <= 1'b1;
            end else if (state == HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE) && !reset;

endmodule

// File: tb/tb_shift_arbiter2.sv
// Bench for shift_arbiter2: scenario tasks plus a scoreboard fed at accept and drained at response.
`timescale 1ns/1ps
module tb_shift_arbiter2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [15:0] req0_data = '0;
    logic [3:0]  req0_amt = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [15:0] req1_data = '0;
    logic [3:0]  req1_amt = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic        busy;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        id;
    } exp_t;

    exp_t sb[$];

    shift_arbiter2 dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Push the expected result at every accept, compare at every response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (req0_valid && req0_ready) sb.push_back('{data: req0_data >> req0_amt, id: 1'b0});
            if (req1_valid && req1_ready) sb.push_back('{data: req1_data >> req1_amt, id: 1'b1});
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rsp_unexpected got data=%h id=%0d, required no response", rsp_data, rsp_id);
                end else begin
                    passed++;
                    e = sb.pop_front();
                    checks++;
                    if (rsp_data !== e.data) $display("FAIL rsp_data got %h required %h", rsp_data, e.data);
                    else passed++;
                    checks++;
                    if (rsp_id !== e.id) $display("FAIL rsp_id got %0d required %0d", rsp_id, e.id);
                    else passed++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (sb.size() != 0) $display("FAIL drain got %0d pending required 0", sb.size());
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b0) $display("FAIL reset_ready0 got %b required 0", req0_ready); else passed++;
        checks++; if (req1_ready !== 1'b0) $display("FAIL reset_ready1 got %b required 0", req1_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b required 0", busy); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b required 0", rsp_valid); else passed++;
        checks++; if (rsp_data !== 16'h0000) $display("FAIL reset_rsp_data got %h required 0000", rsp_data); else passed++;
        checks++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id got %b required 0", rsp_id); else passed++;
        cyc();
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %b required 0", busy); else passed++;
        cyc();
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        req0_data = 16'hF0F0;
        req0_amt = 4'd4;
        req0_valid = 1'b1;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1) $display("FAIL single_ready0 got %b required 1", req0_ready); else passed++;
        checks++; if (req1_ready !== 1'b0) $display("FAIL single_ready1 got %b required 0", req1_ready); else passed++;
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) $display("FAIL single_shift_valid got %b required 0", rsp_valid); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL single_shift_busy got %b required 1", busy); else passed++;
        cyc();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid got %b required 1", rsp_valid); else passed++;
        checks++; if (rsp_data !== 16'h0F0F) $display("FAIL single_rsp_data got %h required 0f0f", rsp_data); else passed++;
        cyc();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) $display("FAIL single_release_valid got %b required 0", rsp_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL single_release_busy got %b required 0", busy); else passed++;
        cyc();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int ids[4];
        int times[4];
        int n = 0;
        do_reset();
        rsp_ready = 1'b1;
        req0_data = 16'h8000; req0_amt = 4'd15;
        req1_data = 16'hFFFF; req1_amt = 4'd0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin ids[n] = 0; times[n] = c; n++; end
            else if (req1_valid && req1_ready) begin ids[n] = 1; times[n] = c; n++; end
            cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (n != 4) $display("FAIL b2b_count got %0d accepts required 4", n);
        else begin
            passed++;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ids[k] != (k % 2)) $display("FAIL b2b_order[%0d] got %0d required %0d", k, ids[k], k % 2);
                else passed++;
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (times[k] - times[k-1] != 3) $display("FAIL b2b_period[%0d] got %0d required 3", k, times[k] - times[k-1]);
                else passed++;
            end
        end
        wait_drain();
    endtask

    task automatic test_lone_req1();
        do_reset();
        rsp_ready = 1'b1;
        req1_data = 16'h1234;
        req1_amt = 4'd3;
        req1_valid = 1'b1;
        @(negedge clk);
        checks++; if (req1_ready !== 1'b1) $display("FAIL lone_ready1 got %b required 1", req1_ready); else passed++;
        checks++; if (req0_ready !== 1'b0) $display("FAIL lone_ready0 got %b required 0", req0_ready); else passed++;
        cyc();
        req1_valid = 1'b0;
        cyc();
        @(negedge clk);
        checks++; if (rsp_id !== 1'b1) $display("FAIL lone_rsp_id got %b required 1", rsp_id); else passed++;
        cyc();
        wait_drain();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req0_data = 16'hBEEF;
        req0_amt = 4'd8;
        req0_valid = 1'b1;
        @(negedge clk);
        cyc();
        req0_data = 16'h1111;
        req1_data = 16'h2222;
        req1_valid = 1'b1;
        cyc();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b required 1", k, rsp_valid); else passed++;
            checks++; if (rsp_data !== 16'h00BE) $display("FAIL bp_data[%0d] got %h required 00be", k, rsp_data); else passed++;
            checks++; if (rsp_id !== 1'b0) $display("FAIL bp_id[%0d] got %b required 0", k, rsp_id); else passed++;
            checks++; if (req0_ready !== 1'b0) $display("FAIL bp_ready0[%0d] got %b required 0", k, req0_ready); else passed++;
            checks++; if (req1_ready !== 1'b0) $display("FAIL bp_ready1[%0d] got %b required 0", k, req1_ready); else passed++;
            checks++; if (busy !== 1'b1) $display("FAIL bp_busy[%0d] got %b required 1", k, busy); else passed++;
            cyc();
        end
        rsp_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_release_valid got %b required 0", rsp_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL bp_release_busy got %b required 0", busy); else passed++;
        checks++; if (rsp_data !== 16'h00BE) $display("FAIL bp_release_data got %h required 00be", rsp_data); else passed++;
        cyc();
        wait_drain();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        req0_data = 16'h5555;
        req0_amt = 4'd1;
        req0_valid = 1'b1;
        @(negedge clk);
        cyc();
        req0_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rmid_valid got %b required 0", rsp_valid); else passed++;
        checks++; if (rsp_data !== 16'h0000) $display("FAIL rmid_data got %h required 0000", rsp_data); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b required 0", busy); else passed++;
        cyc();
        req0_data = 16'h00F0; req0_amt = 4'd4;
        req1_data = 16'h0F00; req1_amt = 4'd8;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1) $display("FAIL rmid_prio_ready0 got %b required 1", req0_ready); else passed++;
        checks++; if (req1_ready !== 1'b0) $display("FAIL rmid_prio_ready1 got %b required 0", req1_ready); else passed++;
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) cyc();
        wait_drain();
    endtask

    task automatic test_sweep();
        logic got;
        logic r;
        rsp_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            r = 1'(a % 2);
            if (r) begin req1_data = 16'hA5C3; req1_amt = 4'(a); req1_valid = 1'b1; end
            else   begin req0_data = 16'hA5C3; req0_amt = 4'(a); req0_valid = 1'b1; end
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                got = r ? req1_ready : req0_ready;
                if (!got) cyc();
            end
            checks++;
            if (!got) $display("FAIL sweep_grant[%0d] got no ready required ready", a);
            else passed++;
            cyc();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            wait_drain();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lone_req1();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        repeat (4) cyc();
        checks++;
        if (sb.size() != 0) $display("FAIL final_scoreboard got %0d pending required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/shift_arbiter2.md
# shift_arbiter2

Two-port round-robin arbiter and sequencer for the shared 16-bit logical right barrel shifter. It accepts shift requests (operand plus 4-bit amount) from two requesters over valid/ready handshakes and runs one operation at a time through the shifter. It returns the registered result with the requester ID over a valid/ready response channel. It sits between the lab datapath's two shift users and the single `barrel_shifter_right16` instance.

## Interface
Parameters:
- none; operand width is fixed at 16 and amount width at 4 by the shifter datapath.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a request.
- `req0_ready`  out  1  requester 0 request accepted this cycle when valid and ready are both high.
- `req0_data`  in  16  requester 0 operand.
- `req0_amt`  in  4  requester 0 right-shift amount, 0..15.
- `req1_valid`, `req1_ready`, `req1_data`, `req1_amt`  same as the requester 0 ports, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_data`  out  16  shifted operand.
- `rsp_id`  out  1  requester that owns the result.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, SHIFT, HOLD.
- IDLE grant rule:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester selected by the priority pointer `prio`.
  - `reqN_ready = (state==IDLE) && grantN`. At most one ready is high; both are low outside IDLE.
- On accept (IDLE, granted valid && ready):
  - Latch operand, amount and ID into operand registers.
  - Set `prio` to the non-granted requester.
  - Go to SHIFT.
- SHIFT:
  - The shifter computes combinationally from the operand registers; logical shift, zero fill.
  - Capture the result into `rsp_data` and the ID into `rsp_id`; set `rsp_valid`=1; go to HOLD.
- HOLD:
  - `rsp_valid`, `rsp_data` and `rsp_id` stay stable.
  - On `rsp_ready`=1: clear `rsp_valid` and go to IDLE. `rsp_data` and `rsp_id` keep their last value.
  - No new request is accepted in the same cycle as the release.
- Arithmetic: `rsp_data = operand >> amt`, 16-bit, zero-filled. Amount 0 passes the operand through; amount 15 leaves only bit 15 in bit 0.
- `prio` changes only on an accept. A lone requester does not consume the other requester's turn beyond this rule.
- Reset values:
  - State IDLE, `prio`=0 (req0 favoured).
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, operand registers 0.
  - `busy`=0, both readies 0 during reset.
- Reset mid-operation (SHIFT or HOLD): the operation is discarded and no response is issued. The next cycle after reset deasserts behaves as the first cycle out of reset.
- Request inputs are sampled only at accept. Changes while not ready are ignored.

## Timing
- Accept at edge N; `rsp_valid` is high after edge N+1 (SHIFT at N, result registered at N+1).
- Minimum period: one operation per 3 cycles (IDLE accept, SHIFT, HOLD with `rsp_ready` already high).
- `reqN_ready` is combinational from `reqN_valid`, the other valid, `prio` and state. There is no combinational path from `reqN_data`/`reqN_amt` to any output.
- `rsp_*` outputs are fully registered.

## Structure
- Shared package holds:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2.
  - Width constants: DATA_W=16, AMT_W=4.
- One sub-module: `barrel_shifter_right16`, instantiated once.
  - Inputs: operand register, and `j0`..`j3` = `amt[0]`..`amt[3]`.
- Arbiter, FSM and registers live in the top module, with no further hierarchy.

## Test plan
- Single request: req0 0xF0F0, amount 4, `rsp_ready`=1 → `req0_ready` high the same cycle; `rsp_valid` 2 cycles later with `rsp_data`=0x0F0F, `rsp_id`=0.
- Simultaneous requests after reset: req0 0x8000/15 and req1 0xFFFF/0, both held valid → req0 served first (0x0001, ID 0), then req1 (0xFFFF, ID 1). Over 4 operations, IDs alternate 0,1,0,1.
- Lone req1 with `prio`=0 → granted on the first IDLE cycle with no idle gap; `rsp_id`=1.
- Backpressure: `rsp_ready` low for 5 cycles in HOLD → `rsp_valid`/`rsp_data`/`rsp_id` stable, both readies 0, `busy`=1. Release → IDLE the next cycle.
- Reset asserted during SHIFT → next cycle `rsp_valid`=0, `rsp_data`=0, `busy`=0, `prio`=0. No response ever appears for the dropped request.
- Amount sweep 0..15 on 0xA5C3 from alternating requesters → each `rsp_data` equals 0xA5C3 >> amt, and `rsp_id` matches the requester.
